// File: rtl/mul_cpa_stage.sv
// Final carry-propagate stage of the Wallace multiplier: two-register pipeline, valid/ready with flush.
// Define MUL_CPA_SINGLE_CYCLE_EN to resolve all 128 bits in S1 instead of the split 64+64 adder.

module rca_nbit #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin : ripple
    logic c;
    c    = cin;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module mul_cpa_stage #(
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [127:0]     i_sum,
  input  logic [127:0]     i_carry,
  input  logic [2:0]       i_op,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [63:0]      o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  logic             s1_valid;
  logic [127:0]     s1_sum;
  logic [127:0]     s1_carry;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [2:0]       s2_op;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_adv;
  logic             s1_adv;
  logic             s1_load;
  logic             s2_load;
  logic [63:0]      lo_res;
  logic [63:0]      hi_res;
  logic [63:0]      result;

  assign s2_adv  = !s2_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv;
  assign s1_load = i_valid && s1_adv && !i_flush;
  assign s2_load = s1_valid && s2_adv && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_op    <= '0;
      s2_tag   <= '0;
    end else begin
      if (i_flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s1_adv) s1_valid <= i_valid;
        if (s2_adv) s2_valid <= s1_valid;
      end
      if (s1_load) begin
        s1_sum   <= i_sum;
        s1_carry <= i_carry;
        s1_op    <= i_op;
        s1_tag   <= i_tag;
      end
      if (s2_load) begin
        s2_op  <= s1_op;
        s2_tag <= s1_tag;
      end
    end
  end

`ifdef MUL_CPA_SINGLE_CYCLE_EN
  logic [127:0] full_sum;
  logic         unused_full_cout;
  logic [127:0] s2_prod;

  rca_nbit #(.N(128)) u_rca_full (
    .a    (s1_sum),
    .b    (s1_carry),
    .cin  (1'b0),
    .sum  (full_sum),
    .cout (unused_full_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_prod <= '0;
    end else if (s2_load) begin
      s2_prod <= full_sum;
    end
  end

  assign lo_res = s2_prod[63:0];
  assign hi_res = s2_prod[127:64];
`else
  logic [63:0] lo_sum;
  logic        lo_cout;
  logic [63:0] s2_lo;
  logic        s2_lo_cout;
  logic [63:0] s2_sum_hi;
  logic [63:0] s2_carry_hi;
  logic [63:0] hi_sum;
  logic        unused_hi_cout;

  rca_nbit #(.N(64)) u_rca_lo (
    .a    (s1_sum[63:0]),
    .b    (s1_carry[63:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_lo       <= '0;
      s2_lo_cout  <= 1'b0;
      s2_sum_hi   <= '0;
      s2_carry_hi <= '0;
    end else if (s2_load) begin
      s2_lo       <= lo_sum;
      s2_lo_cout  <= lo_cout;
      s2_sum_hi   <= s1_sum[127:64];
      s2_carry_hi <= s1_carry[127:64];
    end
  end

  // Carry out of bit 127 is dropped: the product is taken mod 2^128.
  rca_nbit #(.N(64)) u_rca_hi (
    .a    (s2_sum_hi),
    .b    (s2_carry_hi),
    .cin  (s2_lo_cout),
    .sum  (hi_sum),
    .cout (unused_hi_cout)
  );

  assign lo_res = s2_lo;
  assign hi_res = hi_sum;
`endif

  always_comb begin
    result = '0;
    if (s2_valid) begin
      case (s2_op)
        OP_MUL:                        result = lo_res;
        OP_MULH, OP_MULHSU, OP_MULHU:  result = hi_res;
        OP_MULW:                       result = {{32{lo_res[31]}}, lo_res[31:0]};
        default:                       result = '0;
      endcase
    end
  end

  assign o_valid  = s2_valid;
  assign o_result = result;
  assign o_tag    = s2_tag;

endmodule

// File: tb/tb_mul_cpa_stage.sv
// Randomized and directed checks of mul_cpa_stage against an in-order queue model.
module tb_mul_cpa_stage;

  localparam int TAG_W = 5;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [127:0]     i_sum;
  logic [127:0]     i_carry;
  logic [2:0]       i_op;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [63:0]      o_result;
  logic [TAG_W-1:0] o_tag;

  mul_cpa_stage #(.TAG_W(TAG_W)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sum    (i_sum),
    .i_carry  (i_carry),
    .i_op     (i_op),
    .i_tag    (i_tag),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_tag    (o_tag)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  always @(posedge i_clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [127:0] s, input logic [127:0] c,
                                             input logic [2:0] op);
    logic [127:0] p;
    p = s + c;
    case (op)
      3'd0:             return p[63:0];
      3'd1, 3'd2, 3'd3: return p[127:64];
      3'd4:             return {{32{p[31]}}, p[31:0]};
      default:          return 64'h0;
    endcase
  endfunction

  typedef struct {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    int               acc;
  } ent_t;

  ent_t             q[$];
  logic             stall_prev = 1'b0;
  logic [63:0]      prev_res;
  logic [TAG_W-1:0] prev_tag;

  // Model: entries in flight, in order; the oldest is visible one edge after its accept edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      int  n;
      logic exp_valid;
      n = q.size();
      exp_valid = (n > 0) && (cycle - q[0].acc >= 1);
      chk("o_valid", 64'(o_valid), 64'(exp_valid));
      chk("o_ready", 64'(o_ready), 64'((n < 2) || i_ready));
      if (o_valid && n > 0) begin
        chk("o_result", o_result, q[0].res);
        chk("o_tag", 64'(o_tag), 64'(q[0].tag));
      end else if (!o_valid) begin
        chk("o_result_idle", o_result, 64'h0);
      end
      if (stall_prev) begin
        chk("stall_valid", 64'(o_valid), 64'h1);
        chk("stall_result", o_result, prev_res);
        chk("stall_tag", 64'(o_tag), 64'(prev_tag));
      end
      stall_prev = o_valid && !i_ready && !i_flush;
      prev_res   = o_result;
      prev_tag   = o_tag;
      if (o_valid && i_ready && n > 0) void'(q.pop_front());
      if (i_flush) q.delete();
      else if (i_valid && o_ready)
        q.push_back('{ref_result(i_sum, i_carry, i_op), i_tag, cycle + 1});
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_sum   = '0;
    i_carry = '0;
    i_op    = '0;
    i_tag   = '0;
  endtask

  task automatic drain;
    idle_inputs();
    i_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_lit(input string name, input logic [127:0] s, input logic [127:0] c,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag,
                          input logic [63:0] exp);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_sum   = s;
    i_carry = c;
    i_op    = op;
    i_tag   = tag;
    tick();
    idle_inputs();
    chk({name, "_s1_hidden"}, 64'(o_valid), 64'h0);
    tick();
    chk({name, "_valid"}, 64'(o_valid), 64'h1);
    chk({name, "_result"}, o_result, exp);
    chk({name, "_tag"}, 64'(o_tag), 64'(tag));
    tick();
  endtask

  task automatic fill_two(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_sum   = 128'h1234;
    i_carry = 128'h10;
    i_op    = 3'd0;
    i_tag   = t0;
    tick();
    i_tag   = t1;
    tick();
    i_valid = 1'b0;
    chk("fill_s2_valid", 64'(o_valid), 64'h1);
    chk("fill_s2_tag", 64'(o_tag), 64'(t0));
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_ready = 1'b1;
    idle_inputs();
    #2;
    chk("rst_o_valid", 64'(o_valid), 64'h0);
    chk("rst_o_result", o_result, 64'h0);
    chk("rst_o_tag", 64'(o_tag), 64'h0);
    chk("rst_o_ready", 64'(o_ready), 64'h1);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    tick();

    // Hand-computed anchors.
    send_lit("basic", 128'h3, 128'h5, 3'd0, 5'd1, 64'h8);
    send_lit("xcarry", 128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 3'd3, 5'd2, 64'h1);
    send_lit("mulw", 128'h8000_0000, 128'h0, 3'd4, 5'd3, 64'hFFFF_FFFF_8000_0000);
    send_lit("rsvd", 128'hDEAD_BEEF, 128'h1111, 3'd7, 5'd4, 64'h0);
    send_lit("mulh", {64'h1, 64'h8000_0000_0000_0000}, {64'h2, 64'h8000_0000_0000_0000},
             3'd1, 5'd5, 64'h4);

    // Backpressure: four back-to-back inputs, downstream stalled for four cycles.
    begin
      int          nxt = 1;
      int          got[$];
      int          gc[$];
      logic [63:0] held = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        logic acc;
        i_ready = (cyc >= 4);
        i_valid = (nxt <= 4);
        i_sum   = 128'(nxt) * 128'h101;
        i_carry = 128'h7;
        i_op    = 3'd0;
        i_tag   = TAG_W'(nxt);
        #1;
        acc = i_valid && o_ready;
        if (o_valid && i_ready) begin
          got.push_back(int'(o_tag));
          gc.push_back(cyc);
        end
        if (cyc == 2) begin
          chk("bp_ready_drop", 64'(o_ready), 64'h0);
          held = o_result;
        end
        if (cyc == 3) begin
          chk("bp_ready_low", 64'(o_ready), 64'h0);
          chk("bp_hold_result", o_result, held);
          chk("bp_hold_tag", 64'(o_tag), 64'h1);
        end
        tick();
        if (acc) nxt++;
        if (got.size() == 4) break;
      end
      chk("bp_count", 64'(got.size()), 64'd4);
      for (int i = 0; i < got.size(); i++) begin
        chk("bp_tag_order", 64'(got[i]), 64'(i + 1));
        chk("bp_no_gap", 64'(gc[i] - gc[0]), 64'(i));
      end
    end
    drain();

    // Flush with both stages full; the flushed tags must never appear.
    begin
      int seen = 0;
      fill_two(5'd9, 5'd10);
      i_flush = 1'b1;
      i_valid = 1'b1;
      i_tag   = 5'd11;
      tick();
      idle_inputs();
      chk("flush_o_valid", 64'(o_valid), 64'h0);
      i_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (o_valid) seen++;
        tick();
      end
      chk("flush_no_output", 64'(seen), 64'h0);
    end

    // Asynchronous reset with both stages full.
    fill_two(5'd12, 5'd13);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_o_valid", 64'(o_valid), 64'h0);
    chk("arst_o_result", o_result, 64'h0);
    chk("arst_o_tag", 64'(o_tag), 64'h0);
    chk("arst_o_ready", 64'(o_ready), 64'h1);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    tick();
    send_lit("post_rst", 128'h40, 128'h2, 3'd0, 5'd14, 64'h42);

    // Randomized traffic with occasional flushes and carry-heavy operands.
    for (int i = 0; i < 3000; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_flush = ($urandom_range(0, 39) == 0);
      i_op    = 3'($urandom_range(0, 7));
      i_tag   = TAG_W'($urandom);
      i_carry = {$urandom, $urandom, $urandom, $urandom};
      i_sum   = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) i_sum[63:0] = 64'hFFFF_FFFF_FFFF_FFFF - i_carry[63:0] + 64'h1;
      if ($urandom_range(0, 7) == 0) i_sum[127:64] = ~i_carry[127:64];
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
